// File: rtl/dsp_div_pkg.sv
// Shared types and sizing helpers for the iterative signed divider.
package dsp_div_pkg;

  localparam int unsigned DividendW = 38;
  localparam int unsigned DivisorW  = 18;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix,
    StDone
  } state_e;

  // Counter must reach DIVIDEND_W itself, not just DIVIDEND_W-1.
  function automatic int unsigned cnt_width(int unsigned dividend_w);
    return $clog2(dividend_w + 1);
  endfunction

endpackage

// File: rtl/dsp_div_abs_neg.sv
// Conditional two's-complement negate: value_o = neg_i ? -value_i : value_i.
module dsp_div_abs_neg #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] value_i,
  input  logic             neg_i,
  output logic [Width-1:0] value_o
);

  always_comb begin
    value_o = value_i;
    if (neg_i) begin
      value_o = ~value_i + Width'(1);
    end
  end

endmodule

// File: rtl/dsp_div_signed_iterative.sv
// Multi-cycle restoring signed divider, one quotient bit per clock, valid/ready both sides.
// Define DSP_DIV_REMAINDER_EN to build the rem_o port and remainder sign correction.
module dsp_div_signed_iterative
  import dsp_div_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = DividendW,
  parameter int unsigned DIVISOR_W  = DivisorW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DIVIDEND_W-1:0] dividend_i,
  input  logic [DIVISOR_W-1:0]  divisor_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DIVIDEND_W-1:0] quot_o,
`ifdef DSP_DIV_REMAINDER_EN
  output logic [DIVISOR_W-1:0]  rem_o,
`endif
  output logic                  dbz_o,
  output logic                  ovf_o
);

  localparam int unsigned CntW = cnt_width(DIVIDEND_W);

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;    // dividend magnitude, becomes quotient magnitude
  logic [DIVISOR_W:0]    prem_q, prem_d;  // partial remainder
  logic [DIVISOR_W-1:0]  dsr_q, dsr_d;    // divisor magnitude
  logic                  qneg_q, qneg_d;
  logic                  dbz_q, dbz_d;
  logic                  ovf_q, ovf_d;
  logic [DIVIDEND_W-1:0] quot_q, quot_d;
`ifdef DSP_DIV_REMAINDER_EN
  logic                  rneg_q, rneg_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [DIVISOR_W-1:0]  rem_fix;
`endif

  logic [DIVIDEND_W-1:0] dvd_abs;
  logic [DIVISOR_W-1:0]  dsr_abs;
  logic [DIVIDEND_W-1:0] quot_fix;
  logic [DIVISOR_W:0]    shifted;
  logic [DIVISOR_W:0]    diff;
  logic                  fits;
  logic                  dividend_neg;
  logic                  divisor_neg;
  logic                  divisor_zero;
  logic                  is_ovf;

  assign dividend_neg = dividend_i[DIVIDEND_W-1];
  assign divisor_neg  = divisor_i[DIVISOR_W-1];
  assign divisor_zero = (divisor_i == '0);
  assign is_ovf       = (dividend_i == {1'b1, {(DIVIDEND_W-1){1'b0}}}) && (divisor_i == '1);

  dsp_div_abs_neg #(
    .Width (DIVIDEND_W)
  ) u_dvd_abs (
    .value_i (dividend_i),
    .neg_i   (dividend_neg),
    .value_o (dvd_abs)
  );

  dsp_div_abs_neg #(
    .Width (DIVISOR_W)
  ) u_dsr_abs (
    .value_i (divisor_i),
    .neg_i   (divisor_neg),
    .value_o (dsr_abs)
  );

  dsp_div_abs_neg #(
    .Width (DIVIDEND_W)
  ) u_quot_fix (
    .value_i (dvd_q),
    .neg_i   (qneg_q),
    .value_o (quot_fix)
  );

`ifdef DSP_DIV_REMAINDER_EN
  dsp_div_abs_neg #(
    .Width (DIVISOR_W)
  ) u_rem_fix (
    .value_i (prem_q[DIVISOR_W-1:0]),
    .neg_i   (rneg_q),
    .value_o (rem_fix)
  );
`endif

  // Partial remainder stays below |divisor|, so its top bit is normally clear; it is still
  // folded into the trial compare so the shift can never silently lose a bit.
  assign shifted = {prem_q[DIVISOR_W-1:0], dvd_q[DIVIDEND_W-1]};
  assign diff    = shifted - {1'b0, dsr_q};
  assign fits    = prem_q[DIVISOR_W] || (shifted >= {1'b0, dsr_q});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    prem_d  = prem_q;
    dsr_d   = dsr_q;
    qneg_d  = qneg_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    quot_d  = quot_q;
`ifdef DSP_DIV_REMAINDER_EN
    rneg_d  = rneg_q;
    rem_d   = rem_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          cnt_d  = '0;
          dbz_d  = divisor_zero;
          ovf_d  = is_ovf;
          dsr_d  = dsr_abs;
          qneg_d = dividend_neg ^ divisor_neg;
`ifdef DSP_DIV_REMAINDER_EN
          rneg_d = dividend_neg;
`endif
          if (divisor_zero) begin
            // Raw dividend low bits pass straight through as the remainder.
            dvd_d   = '1;
            prem_d  = {1'b0, dividend_i[DIVISOR_W-1:0]};
            qneg_d  = 1'b0;
`ifdef DSP_DIV_REMAINDER_EN
            rneg_d  = 1'b0;
`endif
            state_d = StFix;
          end else begin
            dvd_d   = dvd_abs;
            prem_d  = '0;
            state_d = StRun;
          end
        end
      end

      StRun: begin
        cnt_d = cnt_q + CntW'(1);
        // Counts 0..DIVIDEND_W-1 iterate; the final count is a settle cycle.
        if (cnt_q == CntW'(DIVIDEND_W)) begin
          state_d = StFix;
        end else begin
          dvd_d  = {dvd_q[DIVIDEND_W-2:0], fits};
          prem_d = fits ? diff : shifted;
        end
      end

      StFix: begin
        quot_d  = quot_fix;
`ifdef DSP_DIV_REMAINDER_EN
        rem_d   = rem_fix;
`endif
        state_d = StDone;
      end

      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dvd_q   <= '0;
      prem_q  <= '0;
      dsr_q   <= '0;
      qneg_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      quot_q  <= '0;
`ifdef DSP_DIV_REMAINDER_EN
      rneg_q  <= 1'b0;
      rem_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      prem_q  <= prem_d;
      dsr_q   <= dsr_d;
      qneg_q  <= qneg_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
      quot_q  <= quot_d;
`ifdef DSP_DIV_REMAINDER_EN
      rneg_q  <= rneg_d;
      rem_q   <= rem_d;
`endif
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign quot_o      = quot_q;
  assign dbz_o       = dbz_q;
  assign ovf_o       = ovf_q;
`ifdef DSP_DIV_REMAINDER_EN
  assign rem_o       = rem_q;
`endif

endmodule
